sram_arbiter: RTL and testbench

- Two-port arbiter and access sequencer in front of the asynchronous SRAM bridge (active-low chip-select, byte-enable, read and write strobes).
- Accepts Avalon-MM style requests from two masters, for example port 0 = CPU and port 1 = video/DMA.
- Grants one transfer at a time using round-robin priority, and generates timed SRAM strobes with a fixed wait-state count.
- Returns read data and releases waitrequest when each transfer completes.

---
 rtl/sram_arbiter_if.sv | 27 ++
 rtl/sram_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_sram_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// Avalon-MM style request port between one bus master and the SRAM arbiter.
// Latency: none, this is wiring only.
// Backpressure: the slave holds waitrequest high until the completion cycle of the transfer.
interface sram_arbiter_if #(
    parameter int DATA_BITS = 16,
    parameter int ADDR_BITS = 20
);
    logic [ADDR_BITS-1:0]   address;
    logic                   read;
    logic                   write;
    logic [DATA_BITS/8-1:0] byteenable;
    logic [DATA_BITS-1:0]   writedata;
    logic [DATA_BITS-1:0]   readdata;
    logic                   waitrequest;

    // Bus master: issues requests and holds them while waitrequest is high.
    modport master (
        output address, read, write, byteenable, writedata,
        input  readdata, waitrequest
    );

    // Arbiter side: consumes requests, returns data and the completion pulse.
    modport slave (
        input  address, read, write, byteenable, writedata,
        output readdata, waitrequest
    );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter that sequences one asynchronous SRAM access at a time.
// Latency: request sampled in IDLE at cycle t completes (waitrequest low) at t+2+WAIT_CYCLES.
// Backpressure: each port's waitrequest stays high except for the single completion cycle.
module sram_arbiter #(
    parameter int DATA_BITS   = 16,   // multiple of 8
    parameter int ADDR_BITS   = 20,
    parameter int WAIT_CYCLES = 2     // strobe low time, 1..15
) (
    input  logic                   clk,
    input  logic                   reset,
    sram_arbiter_if.slave          m0,
    sram_arbiter_if.slave          m1,
    output logic                   sram_chipselect_n,
    output logic                   sram_read_n,
    output logic                   sram_write_n,
    output logic [DATA_BITS/8-1:0] sram_byteenable_n,
    output logic [ADDR_BITS-1:0]   sram_address,
    output logic [DATA_BITS-1:0]   sram_writedata,
    input  logic [DATA_BITS-1:0]   sram_readdata
);
    localparam int BE_BITS = DATA_BITS / 8;
    localparam int CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state, state_d;

    logic [CNT_W-1:0] cnt, cnt_d;
    logic             last_grant, last_grant_d;
    logic             grant, grant_d;
    logic             is_write, is_write_d;

    // The SRAM pin registers double as the latched address/byteenable/writedata
    // of the granted transfer: they are loaded once on grant and held to DONE.
    logic                 cs_n_q, cs_n_d;
    logic                 rd_n_q, rd_n_d;
    logic                 wr_n_q, wr_n_d;
    logic [BE_BITS-1:0]   be_n_q, be_n_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [DATA_BITS-1:0] wdata_q, wdata_d;

    logic                 wait0_q, wait0_d;
    logic                 wait1_q, wait1_d;
    logic [DATA_BITS-1:0] rdata0_q, rdata0_d;
    logic [DATA_BITS-1:0] rdata1_q, rdata1_d;

    logic req0, req1, sel;

    assign req0 = m0.read | m0.write;
    assign req1 = m1.read | m1.write;

    // On a tie the port that did not win last time goes; a lone requester always wins.
    assign sel = (req0 && req1) ? ~last_grant : ~req0;

    // Next state and next registered outputs; every output is a flop so no
    // master input ever reaches an SRAM pin combinationally.
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        last_grant_d = last_grant;
        grant_d      = grant;
        is_write_d   = is_write;
        cs_n_d       = cs_n_q;
        rd_n_d       = 1'b1;
        wr_n_d       = 1'b1;
        be_n_d       = be_n_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wait0_d      = 1'b1;
        wait1_d      = 1'b1;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_d      = SETUP;
                    grant_d      = sel;
                    last_grant_d = sel;
                    // A simultaneous read+write request is performed as a write.
                    is_write_d   = sel ? m1.write : m0.write;
                    cs_n_d       = 1'b0;
                    be_n_d       = sel ? ~m1.byteenable : ~m0.byteenable;
                    addr_d       = sel ? m1.address : m0.address;
                    wdata_d      = sel ? m1.writedata : m0.writedata;
                end else begin
                    cs_n_d = 1'b1;
                    be_n_d = '1;
                end
            end

            SETUP: begin
                state_d = STROBE;
                cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                rd_n_d  = is_write;
                wr_n_d  = ~is_write;
            end

            STROBE: begin
                if (cnt == '0) begin
                    // Last strobe cycle: sample the bridge and raise the strobe
                    // while chip-select and data stay put for hold time.
                    state_d = DONE;
                    if (!is_write) begin
                        if (grant) begin
                            rdata1_d = sram_readdata;
                        end else begin
                            rdata0_d = sram_readdata;
                        end
                    end
                    wait0_d = grant;
                    wait1_d = ~grant;
                end else begin
                    cnt_d  = cnt - CNT_W'(1);
                    rd_n_d = is_write;
                    wr_n_d = ~is_write;
                end
            end

            DONE: begin
                // The following IDLE cycle is the bus-turnaround gap.
                state_d = IDLE;
                cs_n_d  = 1'b1;
                be_n_d  = '1;
            end

            default: begin
                state_d = IDLE;
                cs_n_d  = 1'b1;
                be_n_d  = '1;
            end
        endcase
    end

    // State, arbitration history and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            is_write   <= 1'b0;
            cs_n_q     <= 1'b1;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            be_n_q     <= '1;
            addr_q     <= '0;
            wdata_q    <= '0;
            wait0_q    <= 1'b1;
            wait1_q    <= 1'b1;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            last_grant <= last_grant_d;
            grant      <= grant_d;
            is_write   <= is_write_d;
            cs_n_q     <= cs_n_d;
            rd_n_q     <= rd_n_d;
            wr_n_q     <= wr_n_d;
            be_n_q     <= be_n_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wait0_q    <= wait0_d;
            wait1_q    <= wait1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    assign sram_chipselect_n = cs_n_q;
    assign sram_read_n       = rd_n_q;
    assign sram_write_n      = wr_n_q;
    assign sram_byteenable_n = be_n_q;
    assign sram_address      = addr_q;
    assign sram_writedata    = wdata_q;

    assign m0.waitrequest = wait0_q;
    assign m1.waitrequest = wait1_q;
    assign m0.readdata    = rdata0_q;
    assign m1.readdata    = rdata1_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with an SRAM model and an in-order completion scoreboard.
// Latency: checks t+2+WAIT_CYCLES completion and WAIT_CYCLES+3 streaming spacing.
// Backpressure: masters hold requests until their waitrequest drops; every wait is bounded.
module tb_sram_arbiter;
    localparam int DB = 16;
    localparam int AB = 20;
    localparam int W  = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          sram_chipselect_n, sram_read_n, sram_write_n;
    logic [1:0]    sram_byteenable_n;
    logic [AB-1:0] sram_address;
    logic [DB-1:0] sram_writedata;
    logic [DB-1:0] sram_readdata = '0;

    sram_arbiter_if #(.DATA_BITS(DB), .ADDR_BITS(AB)) m0_bus ();
    sram_arbiter_if #(.DATA_BITS(DB), .ADDR_BITS(AB)) m1_bus ();

    sram_arbiter #(.DATA_BITS(DB), .ADDR_BITS(AB), .WAIT_CYCLES(W)) dut (
        .clk               (clk),
        .reset             (reset),
        .m0                (m0_bus),
        .m1                (m1_bus),
        .sram_chipselect_n (sram_chipselect_n),
        .sram_read_n       (sram_read_n),
        .sram_write_n      (sram_write_n),
        .sram_byteenable_n (sram_byteenable_n),
        .sram_address      (sram_address),
        .sram_writedata    (sram_writedata),
        .sram_readdata     (sram_readdata)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- SRAM model and reference memory ----------------
    logic [DB-1:0] mem     [logic [AB-1:0]];
    logic [DB-1:0] exp_mem [logic [AB-1:0]];

    function automatic logic [DB-1:0] exp_rd(input logic [AB-1:0] a);
        return exp_mem.exists(a) ? exp_mem[a] : '0;
    endfunction

    task automatic preload(input logic [AB-1:0] a, input logic [DB-1:0] d);
        mem[a]     = d;
        exp_mem[a] = d;
    endtask

    always @(negedge clk) begin
        logic [DB-1:0] t;
        if (!sram_chipselect_n && !sram_write_n) begin
            t = mem.exists(sram_address) ? mem[sram_address] : '0;
            for (int b = 0; b < 2; b++)
                if (!sram_byteenable_n[b]) t[8*b +: 8] = sram_writedata[8*b +: 8];
            mem[sram_address] = t;
        end
        sram_readdata <= mem.exists(sram_address) ? mem[sram_address] : '0;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        bit            port;
        bit            wr;
        logic [AB-1:0] addr;
        logic [DB-1:0] data;
        logic [1:0]    be;
    } exp_t;
    exp_t sb[$];

    task automatic push(input bit port, input bit wr, input logic [AB-1:0] a,
                        input logic [DB-1:0] d, input logic [1:0] be);
        exp_t e;
        logic [DB-1:0] t;
        e.port = port; e.wr = wr; e.addr = a; e.be = be;
        if (wr) begin
            e.data = d;
            t = exp_rd(a);
            for (int b = 0; b < 2; b++)
                if (be[b]) t[8*b +: 8] = d[8*b +: 8];
            exp_mem[a] = t;
        end else begin
            e.data = exp_rd(a);
        end
        sb.push_back(e);
    endtask

    // ---------------- bus monitor ----------------
    int            cyc = 0;
    bit            in_xfer = 0;
    bit            x_unstable = 0;
    logic [AB-1:0] x_addr;
    logic [DB-1:0] x_wd;
    logic [1:0]    x_ben;
    int            rd_cnt = 0, wr_cnt = 0, hi_run = 0;
    logic          prev_w0 = 1'b1, prev_w1 = 1'b1;
    logic [DB-1:0] last_rd0 = '0, last_rd1 = '0;
    int            gaps[$];
    int            done_cyc[$];

    always @(negedge clk) begin
        exp_t          e;
        logic [1:0]    eben;
        bit            p;
        logic [DB-1:0] rd_p, rd_o;
        if (reset) begin
            in_xfer  = 0;
            hi_run   = 0;
            prev_w0  = 1'b1;
            prev_w1  = 1'b1;
            last_rd0 = '0;
            last_rd1 = '0;
        end else begin
            cyc++;
            if (!sram_chipselect_n) begin
                if (!in_xfer) begin
                    in_xfer = 1; x_unstable = 0; rd_cnt = 0; wr_cnt = 0;
                    x_addr = sram_address; x_wd = sram_writedata; x_ben = sram_byteenable_n;
                    gaps.push_back(hi_run);
                end else if (sram_address !== x_addr || sram_writedata !== x_wd ||
                             sram_byteenable_n !== x_ben) begin
                    x_unstable = 1;
                end
                if (!sram_read_n)  rd_cnt++;
                if (!sram_write_n) wr_cnt++;
                hi_run = 0;
            end else begin
                in_xfer = 0;
                hi_run++;
            end

            if (!m0_bus.waitrequest || !m1_bus.waitrequest) begin
                p    = m0_bus.waitrequest;
                rd_p = p ? m1_bus.readdata : m0_bus.readdata;
                rd_o = p ? m0_bus.readdata : m1_bus.readdata;
                chk("other_wait_high", p ? m0_bus.waitrequest : m1_bus.waitrequest, 1);
                chk("wait_single_pulse", p ? prev_w1 : prev_w0, 1);
                chk("other_rdata_hold", rd_o, p ? last_rd0 : last_rd1);
                chk("cs_low_in_done", in_xfer, 1);
                chk("sb_nonempty", (sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e    = sb.pop_front();
                    eben = ~e.be;
                    chk("grant_port", p, e.port);
                    chk("sram_addr", x_addr, e.addr);
                    chk("sram_ben", x_ben, eben);
                    chk("sram_stable", x_unstable, 0);
                    chk("read_n_cycles", rd_cnt, e.wr ? 0 : W);
                    chk("write_n_cycles", wr_cnt, e.wr ? W : 0);
                    if (e.wr) chk("sram_wdata", x_wd, e.data);
                    else      chk("readdata", rd_p, e.data);
                end
                if (p) last_rd1 = rd_p; else last_rd0 = rd_p;
                done_cyc.push_back(cyc);
            end
            prev_w0 = m0_bus.waitrequest;
            prev_w1 = m1_bus.waitrequest;
        end
    end

    // ---------------- master driver ----------------
    function automatic logic wq(input bit p);
        return p ? m1_bus.waitrequest : m0_bus.waitrequest;
    endfunction

    task automatic xfer(input bit p, input bit rd, input bit wr, input logic [AB-1:0] a,
                        input logic [DB-1:0] d, input logic [1:0] be, output int n);
        if (p) begin
            m1_bus.address = a; m1_bus.writedata = d; m1_bus.byteenable = be;
            m1_bus.read = rd; m1_bus.write = wr;
        end else begin
            m0_bus.address = a; m0_bus.writedata = d; m0_bus.byteenable = be;
            m0_bus.read = rd; m0_bus.write = wr;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (wq(p) && n < 100);
        chk("xfer_done", wq(p), 0);
        if (p) begin m1_bus.read = 0; m1_bus.write = 0; end
        else   begin m0_bus.read = 0; m0_bus.write = 0; end
    endtask

    // ---------------- directed sequence ----------------
    logic [AB-1:0] ra[3];
    logic [AB-1:0] wa[3];
    logic [DB-1:0] wd[3];
    logic [1:0]    wbe[3];
    int            n, n0, n1;

    initial begin
        m0_bus.read = 0; m0_bus.write = 0; m0_bus.address = '0;
        m0_bus.writedata = '0; m0_bus.byteenable = '0;
        m1_bus.read = 0; m1_bus.write = 0; m1_bus.address = '0;
        m1_bus.writedata = '0; m1_bus.byteenable = '0;

        preload(20'h00012, 16'hBEEF);
        preload(20'hFFFFF, 16'hAAAA);
        preload(20'h00300, 16'h0F0F);
        for (int i = 0; i < 4; i++) preload(20'h00400 + 20'(i), 16'hC000 + 16'(i * 16'h111));

        ra[0] = 20'hFFFFF; ra[1] = 20'h00012; ra[2] = 20'h00300;
        wa[0] = 20'h00400; wa[1] = 20'h00401; wa[2] = 20'h00402;
        wd[0] = 16'h1111;  wd[1] = 16'h2233;  wd[2] = 16'h4455;
        wbe[0] = 2'b11;    wbe[1] = 2'b01;    wbe[2] = 2'b11;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cs_n", sram_chipselect_n, 1);
        chk("rst_read_n", sram_read_n, 1);
        chk("rst_write_n", sram_write_n, 1);
        chk("rst_ben", sram_byteenable_n, 2'b11);
        chk("rst_addr", sram_address, 0);
        chk("rst_wdata", sram_writedata, 0);
        chk("rst_m0_wait", m0_bus.waitrequest, 1);
        chk("rst_m1_wait", m1_bus.waitrequest, 1);
        chk("rst_m0_rdata", m0_bus.readdata, 0);
        chk("rst_m1_rdata", m1_bus.readdata, 0);
        reset = 0;

        // m0 read from IDLE: completes 2+W cycles after sampling
        push(0, 0, 20'h00012, '0, 2'b11);
        xfer(0, 1, 0, 20'h00012, 16'h0000, 2'b11, n);
        chk("m0_read_latency", n, 2 + W);
        chk("m0_readdata_beef", m0_bus.readdata, 16'hBEEF);

        // m1 partial write to top address, issued during the DONE cycle
        push(1, 1, 20'hFFFFF, 16'h1234, 2'b10);
        xfer(1, 0, 1, 20'hFFFFF, 16'h1234, 2'b10, n);
        chk("m1_write_latency", n, 3 + W);

        // both ports continuously: grants alternate starting with port 0
        for (int i = 0; i < 3; i++) begin
            push(0, 0, ra[i], '0, 2'b11);
            push(1, 1, wa[i], wd[i], wbe[i]);
        end
        done_cyc.delete();
        fork
            begin
                for (int i = 0; i < 3; i++) xfer(0, 1, 0, ra[i], 16'h0, 2'b11, n0);
            end
            begin
                for (int j = 0; j < 3; j++) xfer(1, 0, 1, wa[j], wd[j], wbe[j], n1);
            end
        join
        chk("fair_completions", done_cyc.size(), 6);

        // read and write together: performed as a write
        push(0, 1, 20'h00401, 16'h5A5A, 2'b10);
        xfer(0, 1, 1, 20'h00401, 16'h5A5A, 2'b10, n);

        // m0 streaming reads: every transfer granted, WAIT+3 apart, one idle cycle between
        done_cyc.delete();
        gaps.delete();
        for (int i = 0; i < 4; i++) push(0, 0, 20'h00400 + 20'(i), '0, 2'b11);
        for (int i = 0; i < 4; i++) xfer(0, 1, 0, 20'h00400 + 20'(i), 16'h0, 2'b11, n);
        chk("stream_count", done_cyc.size(), 4);
        chk("stream_gap_count", gaps.size(), 4);
        if (done_cyc.size() == 4 && gaps.size() == 4) begin
            for (int i = 1; i < 4; i++) begin
                chk("stream_spacing", done_cyc[i] - done_cyc[i-1], W + 3);
                chk("stream_cs_gap", gaps[i], 1);
            end
        end

        // async reset in the middle of a write strobe
        m1_bus.address = 20'h00500; m1_bus.writedata = 16'hDEAD;
        m1_bus.byteenable = 2'b11; m1_bus.write = 1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (sram_write_n && n < 50);
        chk("abort_strobe_seen", sram_write_n, 0);
        #1 reset = 1;
        #1;
        chk("abort_write_n", sram_write_n, 1);
        chk("abort_cs_n", sram_chipselect_n, 1);
        chk("abort_m0_wait", m0_bus.waitrequest, 1);
        chk("abort_m1_wait", m1_bus.waitrequest, 1);
        chk("abort_ben", sram_byteenable_n, 2'b11);
        chk("abort_addr", sram_address, 0);
        m1_bus.write = 0;
        repeat (2) @(negedge clk);
        reset = 0;

        // after reset, port 0 wins a simultaneous request
        push(0, 0, 20'h00012, '0, 2'b11);
        push(1, 1, 20'h00501, 16'h7777, 2'b11);
        fork
            xfer(0, 1, 0, 20'h00012, 16'h0, 2'b11, n0);
            xfer(1, 0, 1, 20'h00501, 16'h7777, 2'b11, n1);
        join
        chk("post_reset_m0_first", (n0 < n1), 1);

        repeat (4) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
